// File: rtl/enc_pkg.sv
// Shared constants and helpers for the 8-to-3 request encoder.
package enc_pkg;

   localparam int unsigned N              = 8;
   localparam int unsigned W              = 3;
   localparam int unsigned RST_LAST_GRANT = N - 1;

   function automatic logic onehot_valid(input logic [N-1:0] vec);
      return (vec != '0) && ((vec & (vec - N'(1))) == '0);
   endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational pick of the lowest set bit of vec_i, searching upward from start_i with wrap.
module prio_pick
   import enc_pkg::*;
(
   input  logic [N-1:0] vec_i,
   input  logic [W-1:0] start_i,
   output logic [W-1:0] idx_o,
   output logic         any_o
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W-1:0]   pos;

   always_comb begin
      dbl   = {vec_i, vec_i} >> start_i;
      rot   = dbl[N-1:0];
      pos   = '0;
      any_o = 1'b0;
      // Scan downward so the last hit is the lowest set bit.
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            pos   = W'(i);
            any_o = 1'b1;
         end
      end
      // N is a power of two, so the W-bit add wraps modulo N.
      idx_o = pos + start_i;
   end

endmodule

// File: rtl/encode8_3_req.sv
// Sequential 8-to-3 request encoder: sticky pending vector served one index at a time.
module encode8_3_req
   import enc_pkg::*;
#(
   parameter bit RoundRobin = 1'b0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] req_i,
   output logic [W-1:0] code_o,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [N-1:0] pending_o,
   output logic         overflow_o
);

   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] code_q, code_d;
   logic         valid_q, valid_d;
   logic         overflow_q, overflow_d;
   logic [W-1:0] last_grant_q, last_grant_d;

   logic [W-1:0] start;
   logic [W-1:0] pick_idx;
   logic         pick_any;
   logic         slot_free;
   logic         load;
   logic [N-1:0] clr;

   assign start = RoundRobin ? W'(last_grant_q + W'(1)) : '0;

   prio_pick u_prio_pick (
      .vec_i   (pending_q),
      .start_i (start),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   always_comb begin
      slot_free    = !valid_q || ready_i;
      load         = slot_free && pick_any;
      clr          = load ? (N'(1) << pick_idx) : '0;
      pending_d    = (pending_q & ~clr) | req_i;
      // A fresh req on the bit being granted this edge is a new event, not a loss.
      overflow_d   = |(req_i & pending_q & ~clr);
      valid_d      = slot_free ? pick_any : valid_q;
      code_d       = load ? pick_idx : code_q;
      last_grant_d = load ? pick_idx : last_grant_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pending_q    <= '0;
         code_q       <= '0;
         valid_q      <= 1'b0;
         overflow_q   <= 1'b0;
         last_grant_q <= W'(RST_LAST_GRANT);
      end else begin
         pending_q    <= pending_d;
         code_q       <= code_d;
         valid_q      <= valid_d;
         overflow_q   <= overflow_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign code_o     = code_q;
   assign valid_o    = valid_q;
   assign pending_o  = pending_q;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_encode8_3_req.sv
// Directed bench for encode8_3_req: fixed-priority and round-robin instances share stimulus.
module tb_encode8_3_req;
   import enc_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ready;
   logic [N-1:0] req;

   logic [W-1:0] code_f, code_r;
   logic         valid_f, valid_r;
   logic [N-1:0] pend_f, pend_r;
   logic         ovf_f, ovf_r;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   encode8_3_req #(.RoundRobin(1'b0)) u_fix (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_i      (req),
      .code_o     (code_f),
      .valid_o    (valid_f),
      .ready_i    (ready),
      .pending_o  (pend_f),
      .overflow_o (ovf_f)
   );

   encode8_3_req #(.RoundRobin(1'b1)) u_rr (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_i      (req),
      .code_o     (code_r),
      .valid_o    (valid_r),
      .ready_i    (ready),
      .pending_o  (pend_r),
      .overflow_o (ovf_r)
   );

   task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full output check of the fixed-priority instance.
   task automatic check_fix(input string tag, input logic v, input logic [W-1:0] c,
                            input logic [N-1:0] p, input logic o);
      check_val({tag, ".valid"}, N'(valid_f), N'(v));
      if (v) check_val({tag, ".code"}, N'(code_f), N'(c));
      check_val({tag, ".pending"}, pend_f, p);
      check_val({tag, ".overflow"}, N'(ovf_f), N'(o));
   endtask

   task automatic check_rr(input string tag, input logic v, input logic [W-1:0] c);
      check_val({tag, ".rr_valid"}, N'(valid_r), N'(v));
      if (v) check_val({tag, ".rr_code"}, N'(code_r), N'(c));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      ready = 1'b1;
      req   = 8'hFF;

      // 1: reset holds everything at zero even with all requests asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         check_fix("rst", 1'b0, 3'd0, 8'h00, 1'b0);
         check_val("rst.code", N'(code_f), 8'h00);
         check_rr("rst", 1'b0, 3'd0);
      end
      rst_n = 1'b1;
      req   = '0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_fix("rst_rel", 1'b0, 3'd0, 8'h00, 1'b0);
      end

      // 2: single request
      req = 8'h20;
      tick();
      check_fix("single_pend", 1'b0, 3'd0, 8'h20, 1'b0);
      check_val("single_onehot", N'(onehot_valid(pend_f)), 8'h01);
      req = '0;
      tick();
      check_fix("single_out", 1'b1, 3'd5, 8'h00, 1'b0);
      check_rr("single_out", 1'b1, 3'd5);
      tick();
      check_fix("single_done", 1'b0, 3'd0, 8'h00, 1'b0);

      // 3: fixed priority 2,4,7; round-robin after grant 5 gives 7,2,4
      req = 8'b1001_0100;
      tick();
      check_fix("prio_pend", 1'b0, 3'd0, 8'h94, 1'b0);
      req = '0;
      tick();
      check_fix("prio0", 1'b1, 3'd2, 8'h90, 1'b0);
      check_rr("prio0", 1'b1, 3'd7);
      tick();
      check_fix("prio1", 1'b1, 3'd4, 8'h80, 1'b0);
      check_rr("prio1", 1'b1, 3'd2);
      tick();
      check_fix("prio2", 1'b1, 3'd7, 8'h00, 1'b0);
      check_rr("prio2", 1'b1, 3'd4);
      tick();
      check_fix("prio_done", 1'b0, 3'd0, 8'h00, 1'b0);
      check_rr("prio_done", 1'b0, 3'd0);

      // 4: held requests; round-robin restarts from index 0 after reset
      do_reset();
      req = 8'h81;
      tick();
      check_val("held_pend", pend_f, 8'h81);
      for (int i = 0; i < 7; i++) begin
         tick();
         check_val("held_fix_code", N'(code_f), 8'h00);
         check_val("held_fix_valid", N'(valid_f), 8'h01);
         check_rr("held", 1'b1, (i % 2 == 0) ? 3'd0 : 3'd7);
      end
      req = '0;
      for (int i = 0; i < 3; i++) tick();
      check_fix("held_drain", 1'b0, 3'd0, 8'h00, 1'b0);

      // 5: backpressure and overflow
      do_reset();
      ready = 1'b0;
      req   = 8'h08;
      tick();
      check_fix("bp_p1", 1'b0, 3'd0, 8'h08, 1'b0);
      req = '0;
      tick();
      check_fix("bp_load", 1'b1, 3'd3, 8'h00, 1'b0);
      tick();
      check_fix("bp_hold", 1'b1, 3'd3, 8'h00, 1'b0);
      req = 8'h08;
      tick();
      check_fix("bp_p2", 1'b1, 3'd3, 8'h08, 1'b0);
      req = '0;
      tick();
      check_fix("bp_gap", 1'b1, 3'd3, 8'h08, 1'b0);
      req = 8'h08;
      tick();
      check_fix("bp_ovf", 1'b1, 3'd3, 8'h08, 1'b1);
      req = '0;
      tick();
      check_fix("bp_ovf_end", 1'b1, 3'd3, 8'h08, 1'b0);
      ready = 1'b1;
      tick();
      check_fix("bp_acc1", 1'b1, 3'd3, 8'h00, 1'b0);
      tick();
      check_fix("bp_acc2", 1'b0, 3'd0, 8'h00, 1'b0);

      // 6: reset while a code is presented and others are pending
      ready = 1'b0;
      req   = 8'h02;
      tick();
      req = 8'h0C;
      tick();
      check_fix("mid_pre", 1'b1, 3'd1, 8'h0C, 1'b0);
      req   = 8'h10;
      rst_n = 1'b0;
      tick();
      check_fix("mid_rst", 1'b0, 3'd0, 8'h00, 1'b0);
      check_val("mid_rst.code", N'(code_f), 8'h00);
      rst_n = 1'b1;
      req   = '0;
      ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_fix("mid_idle", 1'b0, 3'd0, 8'h00, 1'b0);
      end
      req = 8'h01;
      tick();
      req = '0;
      tick();
      check_fix("mid_new", 1'b1, 3'd0, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
